// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// response error codes and request kind.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_FAULT    = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } err_e;

  typedef enum logic {
    KIND_LOAD  = 1'b0,
    KIND_STORE = 1'b1
  } kind_e;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane datapath: merges sub-word store data into a memory word and
// extracts/extends the addressed lane of a loaded word.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        sext;

  always_comb begin
    lane_byte = word[{byte_off, 3'b000} +: 8];
    lane_half = byte_off[1] ? word[31:16] : word[15:0];
    // funct3[2] marks the unsigned load variants
    sext      = ~funct3[2];

    merged = word;
    case (funct3[1:0])
      2'b00:   merged[{byte_off, 3'b000} +: 8] = store_data[7:0];
      2'b01: begin
        if (byte_off[1]) merged[31:16] = store_data[15:0];
        else             merged[15:0]  = store_data[15:0];
      end
      default: merged = store_data;
    endcase

    case (funct3[1:0])
      2'b00:   extracted = {{24{sext & lane_byte[7]}}, lane_byte};
      2'b01:   extracted = {{16{sext & lane_half[15]}}, lane_half};
      default: extracted = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: classifies requests, performs read,
// read-modify-write or write on a 4-byte memory port, returns one response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_store_data,
  output logic        resp_valid,
  output logic [1:0]  resp_err,
  output logic [31:0] resp_load_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read_data
);

  state_e      state_q, state_d;
  err_e        err_q, err_d, new_err;
  kind_e       kind_q, kind_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  funct3_q, funct3_d;

  logic [32:0] last_byte;
  logic        illegal, misaligned, fault;
  logic [31:0] merged, extracted;

  lsu_byte_lane u_lane (
    .funct3     (funct3_q),
    .byte_off   (addr_q[1:0]),
    .word       (word_q),
    .store_data (data_q),
    .merged     (merged),
    .extracted  (extracted)
  );

  // 33-bit sum so addresses near 2^32 cannot wrap past the size check
  always_comb begin
    last_byte  = {1'b0, req_addr[31:2], 2'b00} + 33'd3;
    illegal    = (req_is_load == req_is_store)
              || (req_is_load  && !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
              || (req_is_store && !(req_funct3 inside {F3_B, F3_H, F3_W}));
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
              || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    fault      = last_byte >= 33'(MEM_BYTES);
    if (illegal)         new_err = ERR_ILLEGAL;
    else if (misaligned) new_err = ERR_MISALIGN;
    else if (fault)      new_err = ERR_FAULT;
    else                 new_err = ERR_OK;
  end

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    kind_d   = kind_q;
    addr_d   = addr_q;
    data_d   = data_q;
    word_d   = word_q;
    funct3_d = funct3_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          data_d   = req_store_data;
          funct3_d = req_funct3;
          kind_d   = req_is_load ? KIND_LOAD : KIND_STORE;
          err_d    = new_err;
          if (new_err != ERR_OK)                   state_d = S_RESP;
          else if (req_is_load || req_funct3 != F3_W) state_d = S_READ;
          else                                     state_d = S_WRITE;
        end
      end
      S_READ: begin
        word_d  = mem_read_data;
        state_d = (kind_q == KIND_LOAD) ? S_RESP : S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready        = (state_q == S_IDLE) && !reset;
    resp_valid       = 1'b0;
    resp_err         = '0;
    resp_load_data   = '0;
    mem_addr         = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    case (state_q)
      S_READ: begin
        mem_read_enable = 1'b1;
        mem_addr        = {addr_q[31:2], 2'b00};
      end
      S_WRITE: begin
        mem_write_enable = 1'b1;
        mem_addr         = {addr_q[31:2], 2'b00};
        mem_write_data   = merged;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (kind_q == KIND_LOAD && err_q == ERR_OK) resp_load_data = extracted;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      err_q    <= ERR_OK;
      kind_q   <= KIND_LOAD;
      addr_q   <= '0;
      data_q   <= '0;
      word_q   <= '0;
      funct3_q <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      kind_q   <= kind_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      word_q   <= word_d;
      funct3_q <= funct3_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_load, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_store_data;
  logic        resp_valid;
  logic [1:0]  resp_err;
  logic [31:0] resp_load_data, mem_addr, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_is_load      (req_is_load),
    .req_is_store     (req_is_store),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_store_data   (req_store_data),
    .resp_valid       (resp_valid),
    .resp_err         (resp_err),
    .resp_load_data   (resp_load_data),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_read_data    (mem_read_data)
  );

  // Memory model: 1 KiB little-endian, combinational read, posedge write
  logic [7:0] mem [0:1023];
  logic       preload;
  logic [9:0] ma;
  assign ma = mem_addr[9:0];
  assign mem_read_data = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[1] <= 8'h05;
      mem[4] <= 8'h44; mem[5] <= 8'h33; mem[6] <= 8'h22; mem[7] <= 8'h11;
    end else if (mem_write_enable) begin
      mem[ma]         <= mem_write_data[7:0];
      mem[ma + 10'd1] <= mem_write_data[15:8];
      mem[ma + 10'd2] <= mem_write_data[23:16];
      mem[ma + 10'd3] <= mem_write_data[31:24];
    end
  end

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [1:0]  err;
    logic [31:0] data;
    int          lat;
    int          rd;
    int          wr;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [1:0] err, input logic [31:0] data,
                              input int lat, input int rd, input int wr);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata;
    v.err = err; v.data = data; v.lat = lat; v.rd = rd; v.wr = wr;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, input int idx);
    int lat, rd, wr, bad;
    logic got;
    logic [1:0]  e;
    logic [31:0] d;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_is_load = v.ld; req_is_store = v.st;
    req_funct3 = v.f3; req_addr = v.addr; req_store_data = v.sdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = 0; wr = 0; bad = 0; got = 1'b0; e = '0; d = '0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (mem_read_enable)  rd++;
      if (mem_write_enable) wr++;
      if (mem_read_enable && mem_write_enable) bad++;
      if ((mem_read_enable || mem_write_enable) && mem_addr !== {v.addr[31:2], 2'b00}) bad++;
      if (!mem_write_enable && mem_write_data !== 32'd0) bad++;
      if (resp_valid) begin
        got = 1'b1; e = resp_err; d = resp_load_data;
      end else if (resp_err !== 2'b00 || resp_load_data !== 32'd0) bad++;
    end
    check({tag, "_latency"}, lat, v.lat);
    check({tag, "_err"}, {30'd0, e}, {30'd0, v.err});
    check({tag, "_data"}, d, v.data);
    check({tag, "_rd_cycles"}, rd, v.rd);
    check({tag, "_wr_cycles"}, wr, v.wr);
    check({tag, "_port_rules"}, bad, 0);
    @(negedge clk);
    check({tag, "_pulse"}, {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    logic r1, r2, p1, p2;

    vecs[0]  = mk(1, 0, 3'b010, 32'h0,   32'h0,        2'b00, 32'h0000_0500, 2, 1, 0);
    vecs[1]  = mk(0, 1, 3'b000, 32'h5,   32'hAB,       2'b00, 32'h0,         3, 1, 1);
    vecs[2]  = mk(1, 0, 3'b010, 32'h4,   32'h0,        2'b00, 32'h1122_AB44, 2, 1, 0);
    vecs[3]  = mk(0, 1, 3'b001, 32'h6,   32'h1234_7F80, 2'b00, 32'h0,        3, 1, 1);
    vecs[4]  = mk(1, 0, 3'b010, 32'h4,   32'h0,        2'b00, 32'h7F80_AB44, 2, 1, 0);
    vecs[5]  = mk(1, 0, 3'b000, 32'h6,   32'h0,        2'b00, 32'hFFFF_FF80, 2, 1, 0);
    vecs[6]  = mk(1, 0, 3'b100, 32'h6,   32'h0,        2'b00, 32'h0000_0080, 2, 1, 0);
    vecs[7]  = mk(1, 0, 3'b001, 32'h6,   32'h0,        2'b00, 32'h0000_7F80, 2, 1, 0);
    vecs[8]  = mk(1, 0, 3'b001, 32'h4,   32'h0,        2'b00, 32'hFFFF_AB44, 2, 1, 0);
    vecs[9]  = mk(1, 0, 3'b101, 32'h4,   32'h0,        2'b00, 32'h0000_AB44, 2, 1, 0);
    vecs[10] = mk(1, 0, 3'b000, 32'h7,   32'h0,        2'b00, 32'h0000_007F, 2, 1, 0);
    vecs[11] = mk(1, 0, 3'b100, 32'h5,   32'h0,        2'b00, 32'h0000_00AB, 2, 1, 0);
    vecs[12] = mk(1, 0, 3'b001, 32'h3,   32'h0,        2'b01, 32'h0,         1, 0, 0);
    vecs[13] = mk(0, 1, 3'b010, 32'h2,   32'h0,        2'b01, 32'h0,         1, 0, 0);
    vecs[14] = mk(1, 0, 3'b011, 32'h0,   32'h0,        2'b11, 32'h0,         1, 0, 0);
    vecs[15] = mk(0, 1, 3'b010, 32'h3FC, 32'hDEAD_BEEF, 2'b00, 32'h0,        2, 0, 1);
    vecs[16] = mk(1, 0, 3'b010, 32'h3FC, 32'h0,        2'b00, 32'hDEAD_BEEF, 2, 1, 0);
    vecs[17] = mk(1, 0, 3'b010, 32'h400, 32'h0,        2'b10, 32'h0,         1, 0, 0);
    vecs[18] = mk(1, 1, 3'b010, 32'h0,   32'h0,        2'b11, 32'h0,         1, 0, 0);
    vecs[19] = mk(0, 0, 3'b010, 32'h0,   32'h0,        2'b11, 32'h0,         1, 0, 0);
    vecs[20] = mk(0, 1, 3'b100, 32'h0,   32'h0,        2'b11, 32'h0,         1, 0, 0);
    vecs[21] = mk(1, 0, 3'b000, 32'h3FF, 32'h0,        2'b00, 32'hFFFF_FFDE, 2, 1, 0);
    vecs[22] = mk(0, 1, 3'b000, 32'h3FD, 32'h55,       2'b00, 32'h0,         3, 1, 1);
    vecs[23] = mk(1, 0, 3'b010, 32'h3FC, 32'h0,        2'b00, 32'hDEAD_55EF, 2, 1, 0);
    vecs[24] = mk(1, 0, 3'b010, 32'h401, 32'h0,        2'b01, 32'h0,         1, 0, 0);
    vecs[25] = mk(1, 0, 3'b010, 32'hFFFF_FFFC, 32'h0,  2'b10, 32'h0,         1, 0, 0);

    reset = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    req_funct3 = '0; req_addr = '0; req_store_data = '0;
    @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    check("reset_outputs",
          {31'd0, (req_ready | resp_valid | (|resp_err) | (|resp_load_data) | (|mem_addr)
                   | (|mem_write_data) | mem_write_enable | mem_read_enable)}, 32'd0);
    reset = 1'b0;
    #1 check("reset_release_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < NV; i++) run_req(vecs[i], i);

    // req_valid held across a load: no second accept while busy
    @(negedge clk);
    req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0;
    req_funct3 = 3'b010; req_addr = 32'h0;
    @(posedge clk);
    @(negedge clk); r1 = req_ready; p1 = resp_valid;
    @(negedge clk); r2 = req_ready; p2 = resp_valid;
    req_valid = 1'b0;
    check("busy_ready", {30'd0, r1, r2}, 32'd0);
    check("busy_resp", {30'd0, p1, p2}, 32'd1);
    check("busy_load_data", resp_load_data, 32'h0000_0500);
    @(negedge clk);
    check("busy_release", {30'd0, req_ready, resp_valid}, 32'd2);

    // Reset asserted during the WRITE cycle of SH 0x8
    @(negedge clk);
    req_valid = 1'b1; req_is_load = 1'b0; req_is_store = 1'b1;
    req_funct3 = 3'b001; req_addr = 32'h8; req_store_data = 32'h0000_1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_write_active", {31'd0, mem_write_enable}, 32'd1);
    #2 reset = 1'b1;
    #1 check("rst_mid_write_drop", {30'd0, mem_write_enable, req_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("rst_no_resp", seen, 0);
    check("rst_ready_after", {31'd0, req_ready}, 32'd1);
    run_req(mk(1, 0, 3'b010, 32'h8, 32'h0, 2'b00, 32'h0, 2, 1, 0), 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
